// File: rtl/muldiv_unit_pkg.sv
// Shared opcode encoding and iteration constants for the HI/LO multiply/divide unit.
package muldiv_unit_pkg;

    localparam int MD_ITERS = 32;
    localparam int MD_CNT_W = 6;

    typedef enum logic [2:0] {
        MDOP_NONE  = 3'd0,
        MDOP_MULT  = 3'd1,
        MDOP_MULTU = 3'd2,
        MDOP_DIV   = 3'd3,
        MDOP_DIVU  = 3'd4,
        MDOP_MTHI  = 3'd5,
        MDOP_MTLO  = 3'd6
    } md_op_e;

    function automatic logic op_is_signed(input md_op_e o);
        return (o == MDOP_MULT) || (o == MDOP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Radix-2 step engine shared by multiply (shift-add) and restoring divide (shift-subtract).
module muldiv_datapath
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_is_div,
    input  logic [DATA_W-1:0] i_low_init,
    input  logic [DATA_W-1:0] i_opnd_init,
    output logic [DATA_W-1:0] o_acc,
    output logic [DATA_W-1:0] o_low
);

    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_low;
    logic [DATA_W-1:0] r_opnd;

    logic [DATA_W:0]   w_add_a;
    logic [DATA_W:0]   w_add_b;
    logic              w_cin;
    logic [DATA_W+1:0] w_sum;
    logic              w_qbit;

    // One adder: divide computes A + ~B + 1, so the carry out means "no borrow".
    always_comb begin
        w_add_a = '0;
        w_add_b = '0;
        w_cin   = 1'b0;
        if (i_is_div) begin
            w_add_a = {r_acc, r_low[DATA_W-1]};
            w_add_b = ~{1'b0, r_opnd};
            w_cin   = 1'b1;
        end else begin
            w_add_a = {1'b0, r_acc};
            w_add_b = r_low[0] ? {1'b0, r_opnd} : '0;
        end
        w_sum  = {1'b0, w_add_a} + {1'b0, w_add_b} + (DATA_W+2)'(w_cin);
        w_qbit = w_sum[DATA_W+1];
    end

    always_ff @(posedge clock) begin
        if (i_load) begin
            r_acc  <= '0;
            r_low  <= i_low_init;
            r_opnd <= i_opnd_init;
        end else if (i_step) begin
            if (i_is_div) begin
                r_acc <= w_qbit ? w_sum[DATA_W-1:0] : w_add_a[DATA_W-1:0];
                r_low <= {r_low[DATA_W-2:0], w_qbit};
            end else begin
                r_acc <= w_sum[DATA_W:1];
                r_low <= {w_sum[0], r_low[DATA_W-1:1]};
            end
        end
    end

    assign o_acc = r_acc;
    assign o_low = r_low;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: control FSM, sign fix-up and architectural HI/LO.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              flush,
    input  logic              rd_hilo,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              stall
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
        return ~v + DATA_W'(1);
    endfunction

    function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] v);
        return ~v + (2*DATA_W)'(1);
    endfunction

    function automatic logic [DATA_W-1:0] mag_w(input logic [DATA_W-1:0] v, input logic sgn);
        return (sgn && v[DATA_W-1]) ? neg_w(v) : v;
    endfunction

    state_e              r_state;
    state_e              w_state_nxt;
    logic [MD_CNT_W-1:0] r_count;
    logic [MD_CNT_W-1:0] w_count_nxt;
    logic                r_is_div;
    logic                r_div0;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    md_op_e              w_op;
    logic                w_is_mul;
    logic                w_is_div;
    logic                w_signed;
    logic                w_accept;
    logic                w_start;
    logic                w_busy;
    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic [DATA_W-1:0]   w_dp_acc;
    logic [DATA_W-1:0]   w_dp_low;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_fix_hi;
    logic [DATA_W-1:0]   w_fix_lo;

    assign w_op     = md_op_e'(op);
    assign w_is_mul = (w_op == MDOP_MULT) || (w_op == MDOP_MULTU);
    assign w_is_div = (w_op == MDOP_DIV) || (w_op == MDOP_DIVU);
    assign w_signed = op_is_signed(w_op);
    assign w_busy   = (r_state != ST_IDLE);
    assign w_accept = op_valid & ~w_busy & ~flush;
    assign w_start  = w_accept & (w_is_mul | w_is_div);
    assign w_mag_a  = mag_w(rs_data, w_signed);
    assign w_mag_b  = mag_w(rt_data, w_signed);

    muldiv_datapath #(
        .DATA_W(DATA_W)
    ) u_datapath (
        .clock      (clock),
        .i_load     (w_start),
        .i_step     ((r_state == ST_MUL || r_state == ST_DIV) && !flush),
        .i_is_div   (r_is_div),
        .i_low_init (w_is_div ? w_mag_a : w_mag_b),
        .i_opnd_init(w_is_div ? w_mag_b : w_mag_a),
        .o_acc      (w_dp_acc),
        .o_low      (w_dp_low)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = w_is_div ? ST_DIV : ST_MUL;
                    w_count_nxt = '0;
                end
            end
            ST_MUL, ST_DIV: begin
                w_count_nxt = r_count + MD_CNT_W'(1);
                if (r_count == MD_CNT_W'(MD_ITERS - 1)) begin
                    w_state_nxt = ST_FIX;
                end
            end
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush && w_busy) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
        end else if (w_start) begin
            r_is_div <= w_is_div;
            r_div0   <= w_is_div && (rt_data == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (w_start) begin
            r_neg_q <= w_signed && (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
            r_neg_r <= w_signed && rs_data[DATA_W-1];
        end
    end

    // Magnitude result from the datapath gets its signs restored here.
    always_comb begin
        w_prod   = r_neg_q ? neg_2w({w_dp_acc, w_dp_low}) : {w_dp_acc, w_dp_low};
        w_fix_hi = w_prod[2*DATA_W-1:DATA_W];
        w_fix_lo = w_prod[DATA_W-1:0];
        if (r_is_div) begin
            w_fix_hi = r_neg_r ? neg_w(w_dp_acc) : w_dp_acc;
            if (r_div0) begin
                w_fix_lo = '1;
            end else begin
                w_fix_lo = r_neg_q ? neg_w(w_dp_low) : w_dp_low;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == ST_FIX && !flush) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
        end else if (w_accept && w_op == MDOP_MTHI) begin
            r_hi <= rs_data;
        end else if (w_accept && w_op == MDOP_MTLO) begin
            r_lo <= rs_data;
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign busy  = w_busy;
    assign stall = w_busy & (op_valid | rd_hilo) & ~flush;

endmodule
